// File: rtl/sipo_framed.sv
// rtl/sipo_framed.sv - framed serial-in/parallel-out deserialiser with held word and valid strobe
// Optional feature macro: SIPO_PARITY_EN (trailing parity bit per frame, checked into par_err).
module sipo_framed #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_en,
  input  logic                         s_in,
  input  logic                         clr,
  output logic [WIDTH-1:0]             p_out,
  output logic                         p_valid,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         par_err
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], s_in};
    else           sr_next = {s_in, sr[WIDTH-1:1]};
  end

  assign last_bit = (bit_cnt == LAST);
  assign busy     = (bit_cnt != '0);

  // With parity enabled the last bit of a frame is the parity bit, so sr
  // already holds the complete data word when it arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      p_out   <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= 1'b0;
      if (clr) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (s_en) begin
        if (last_bit) begin
          bit_cnt <= '0;
          p_valid <= 1'b1;
          sr      <= '0;
`ifdef SIPO_PARITY_EN
          p_out   <= sr;
`else
          p_out   <= sr_next;
`endif
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
          sr      <= sr_next;
        end
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (!clr && s_en && last_bit) begin
      par_err <= ((^sr) ^ s_in) != ODD_PARITY;
    end
  end
`else
  logic unused_odd_parity;
  assign unused_odd_parity = ODD_PARITY;
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_framed.sv
// tb/tb_sipo_framed.sv - randomized self-checking bench for sipo_framed (both bit orders, WIDTH=4)
module tb_sipo_framed;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, s_en = 1'b0, s_in = 1'b0;
  logic [W-1:0] p_out_m, p_out_l;
  logic p_valid_m, p_valid_l, busy_m, busy_l, par_err_m, par_err_l;
  logic [2:0] bit_cnt_m, bit_cnt_l;
  logic [19:0] obs;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit q_bits[$];
  logic [W-1:0] m_msb = '0, m_lsb = '0;
  logic m_valid = 1'b0, m_err = 1'b0;

  always #5 clk = ~clk;

  sipo_framed #(.WIDTH(W), .MSB_FIRST(1'b1), .ODD_PARITY(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .s_en(s_en), .s_in(s_in), .clr(clr),
    .p_out(p_out_m), .p_valid(p_valid_m), .busy(busy_m), .bit_cnt(bit_cnt_m), .par_err(par_err_m)
  );

  sipo_framed #(.WIDTH(W), .MSB_FIRST(1'b0), .ODD_PARITY(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .s_en(s_en), .s_in(s_in), .clr(clr),
    .p_out(p_out_l), .p_valid(p_valid_l), .busy(busy_l), .bit_cnt(bit_cnt_l), .par_err(par_err_l)
  );

  assign obs = {p_out_m, p_out_l, p_valid_m, p_valid_l, bit_cnt_m, bit_cnt_l,
                busy_m, busy_l, par_err_m, par_err_l};

  // Reference: collect received bits; a full frame becomes a word by position.
  task automatic model_update(input logic r, input logic c, input logic e, input logic d);
    bit x;
    if (r) begin
      q_bits.delete();
      m_msb = '0; m_lsb = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (c) q_bits.delete();
      else if (e) begin
        q_bits.push_back(d);
        if (q_bits.size() == FL) begin
          x = 1'b0;
          for (int i = 0; i < W; i++) begin
            m_msb[W-1-i] = q_bits[i];
            m_lsb[i]     = q_bits[i];
          end
          for (int i = 0; i < FL; i++) x = x ^ q_bits[i];
`ifdef SIPO_PARITY_EN
          m_err = x;
`else
          m_err = 1'b0;
`endif
          m_valid = 1'b1;
          q_bits.delete();
        end
      end
    end
  endtask

  function automatic logic [19:0] exp_vec();
    logic [2:0] n;
    n = 3'(q_bits.size());
    return {m_msb, m_lsb, m_valid, m_valid, n, n, n != 0, n != 0, m_err, m_err};
  endfunction

  function automatic logic frame_bit(input logic [W-1:0] w, input logic par, input int i);
    return (i < W) ? w[W-1-i] : par;
  endfunction

  task automatic step(input logic r, input logic c, input logic e, input logic d);
    rst = r; clr = c; s_en = e; s_in = d;
    @(posedge clk);
    model_update(r, c, e, d);
    cyc++;
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; s_en = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs !== 20'h0) begin failures++; $display("FAIL reset_zero got=%h exp=%h", obs, 20'h0); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_vec()) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    w = 4'b1011;
    for (int i = 0; i < FL; i++) begin
      step(1'b0, 1'b0, 1'b1, frame_bit(w, 1'b1, i));
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL basic_bit%0d got=%h exp=%h", i, obs, exp_vec()); end
      checks++;
      if (bit_cnt_m !== 3'((i + 1) % FL)) begin failures++; $display("FAIL basic_cnt%0d got=%0d exp=%0d", i, bit_cnt_m, (i + 1) % FL); end
    end
    checks++;
    if (p_out_m !== 4'b1011 || p_out_l !== 4'b1101 || p_valid_m !== 1'b1 || par_err_m !== 1'b0) begin
      failures++; $display("FAIL basic_word got=%b/%b v=%b e=%b exp=1011/1101 v=1 e=0", p_out_m, p_out_l, p_valid_m, par_err_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (p_valid_m !== 1'b0 || p_out_m !== 4'b1011) begin failures++; $display("FAIL basic_pulse got v=%b p=%b exp v=0 p=1011", p_valid_m, p_out_m); end
  endtask

  task automatic test_gaps();
    logic [W-1:0] w, prev;
    for (int k = 0; k < 4; k++) begin
      w = 4'($urandom);
      prev = m_msb;
      for (int i = 0; i < FL; i++) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          step(1'b0, 1'b0, 1'b0, 1'($urandom));
          checks++;
          if (obs !== exp_vec()) begin failures++; $display("FAIL gaps_idle got=%h exp=%h", obs, exp_vec()); end
        end
        step(1'b0, 1'b0, 1'b1, frame_bit(w, ^w, i));
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL gaps_bit got=%h exp=%h", obs, exp_vec()); end
        if (i < FL - 1) begin
          checks++;
          if (busy_m !== 1'b1 || p_out_m !== prev) begin failures++; $display("FAIL gaps_hold got busy=%b p=%b exp busy=1 p=%b", busy_m, p_out_m, prev); end
        end
      end
      checks++;
      if (p_out_m !== w) begin failures++; $display("FAIL gaps_word got=%b exp=%b", p_out_m, w); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [2];
    int vc [$];
    words[0] = 4'b1011; words[1] = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < FL; i++) begin
        step(1'b0, 1'b0, 1'b1, frame_bit(words[k], ^words[k], i));
        if (p_valid_m === 1'b1) vc.push_back(cyc);
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL b2b_bit got=%h exp=%h", obs, exp_vec()); end
      end
    end
    checks++;
    if (vc.size() != 2 || (vc.size() == 2 && vc[1] - vc[0] != FL)) begin
      failures++; $display("FAIL b2b_spacing got pulses=%0d exp pulses=2 spacing=%0d", vc.size(), FL);
    end
    checks++;
    if (p_out_m !== 4'b0110) begin failures++; $display("FAIL b2b_word got=%b exp=0110", p_out_m); end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bit_cnt_m !== 3'd0 || p_out_m !== 4'b0110 || p_valid_m !== 1'b0 || busy_m !== 1'b0) begin
      failures++; $display("FAIL b2b_clr got cnt=%0d p=%b v=%b exp cnt=0 p=0110 v=0", bit_cnt_m, p_out_m, p_valid_m);
    end
    for (int i = 0; i < FL; i++) step(1'b0, 1'b0, 1'b1, frame_bit(4'b1001, 1'b0, i));
    checks++;
    if (p_out_m !== 4'b1001 || obs !== exp_vec()) begin failures++; $display("FAIL b2b_after_clr got=%b exp=1001", p_out_m); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== 20'h0) begin failures++; $display("FAIL rst_mid got=%h exp=%h", obs, 20'h0); end
    for (int i = 0; i < FL; i++) step(1'b0, 1'b0, 1'b1, frame_bit(4'b0101, 1'b0, i));
    checks++;
    if (p_out_m !== 4'b0101 || p_out_l !== 4'b1010 || p_valid_m !== 1'b1) begin
      failures++; $display("FAIL rst_mid_word got=%b/%b v=%b exp=0101/1010 v=1", p_out_m, p_out_l, p_valid_m);
    end
  endtask

  task automatic test_parity();
`ifdef SIPO_PARITY_EN
    for (int i = 0; i < FL; i++) step(1'b0, 1'b0, 1'b1, frame_bit(4'b1011, 1'b1, i));
    checks++;
    if (p_out_m !== 4'b1011 || par_err_m !== 1'b0) begin failures++; $display("FAIL par_good got p=%b e=%b exp p=1011 e=0", p_out_m, par_err_m); end
    for (int i = 0; i < FL; i++) step(1'b0, 1'b0, 1'b1, frame_bit(4'b1011, 1'b0, i));
    checks++;
    if (p_out_m !== 4'b1011 || par_err_m !== 1'b1) begin failures++; $display("FAIL par_bad got p=%b e=%b exp p=1011 e=1", p_out_m, par_err_m); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (par_err_m !== 1'b1) begin failures++; $display("FAIL par_hold got=%b exp=1", par_err_m); end
`else
    for (int i = 0; i < 3 * FL; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'($urandom));
      checks++;
      if (par_err_m !== 1'b0 || par_err_l !== 1'b0) begin failures++; $display("FAIL par_tied got=%b%b exp=00", par_err_m, par_err_l); end
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom));
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_rst_mid();
    test_parity();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
